// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: field positions, packet struct and
// router id type used by the routing-logic channels and their merge stage.
package noc_pkg;

  localparam int unsigned WIDTH       = 11;
  localparam int unsigned TYPE_BIT    = 0;
  localparam int unsigned DEST_LSB    = 1;
  localparam int unsigned DEST_MSB    = 3;
  localparam int unsigned PAYLOAD_LSB = 4;
  localparam int unsigned SRC_W       = 2;

  typedef logic [2:0] router_id_t;

  typedef struct packed {
    logic [6:0] payload;
    logic [2:0] dest;
    logic       type_flag;
  } noc_pkt_t;

  function automatic logic [SRC_W-1:0] rr_next(input int unsigned idx, input int unsigned n);
    return SRC_W'((idx + 1) % n);
  endfunction

endpackage

// File: rtl/rl_output_arbiter_if.sv
// Handshake bundle between the routing-logic channels, the merge stage and
// the downstream output link.
interface rl_output_arbiter_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned WIDTH = 11
);
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [1:0]            out_src;
  logic                  misroute;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src, misroute
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src, misroute
  );
endinterface

// File: rtl/noc_pkt_fifo.sv
// Small synchronous FIFO for packet+source entries; head entry is read
// straight from the storage registers.
module noc_pkt_fifo #(
  parameter int unsigned W     = 13,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // When full, push and pop share a slot: the head is read this cycle
      // and overwritten at the edge.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rl_output_arbiter.sv
// Round-robin merge of the routing-logic output channels into one buffered
// output link, with a sticky flag for packets addressed to another router.
module rl_output_arbiter #(
  parameter int unsigned        WIDTH     = noc_pkg::WIDTH,
  parameter int unsigned        N_IN      = 3,
  parameter int unsigned        DEPTH     = 2,
  parameter noc_pkg::router_id_t ROUTER_ID = 3'd2
) (
  input logic               clk,
  input logic               rst_n,
  rl_output_arbiter_if.slave bus
);
  import noc_pkg::*;

  localparam int unsigned ENTRY_W = WIDTH + SRC_W;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_found;
  logic [WIDTH-1:0]   grant_pkt;
  logic               space;
  logic               push;
  logic               pop;
  logic [N_IN-1:0]    in_ready_w;
  logic               misroute_q;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;

  // First valid channel at or above the pointer, wrapping modulo N_IN.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_pkt   = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = (32'(rr_ptr) + k) % N_IN;
      if (!grant_found && bus.in_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(idx);
        grant_pkt   = bus.in_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign pop   = !empty && bus.out_ready;
  assign space = !full || pop;
  // Gating with rst_n keeps in_ready low while reset is asserted.
  assign push  = rst_n && space && grant_found;

  always_comb begin
    in_ready_w = '0;
    if (push) in_ready_w[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      misroute_q <= 1'b0;
    end else if (push) begin
      rr_ptr <= rr_next(32'(grant_idx), N_IN);
      if (grant_pkt[DEST_MSB:DEST_LSB] != ROUTER_ID) misroute_q <= 1'b1;
    end
  end

  noc_pkt_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({grant_idx, grant_pkt}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = head[WIDTH-1:0];
  assign bus.out_src   = head[ENTRY_W-1 -: SRC_W];
  assign bus.misroute  = misroute_q;

endmodule

// File: tb/tb_rl_output_arbiter.sv
// Bench for rl_output_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rl_output_arbiter;
  import noc_pkg::*;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned W     = 11;
  localparam router_id_t  RID   = 3'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rl_output_arbiter_if #(.N_IN(N_IN), .WIDTH(W)) bus ();

  rl_output_arbiter #(
    .WIDTH     (W),
    .N_IN      (N_IN),
    .DEPTH     (DEPTH),
    .ROUTER_ID (RID)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [6:0] pl, input logic [2:0] d, input logic t);
    logic [W-1:0] v;
    v                    = '0;
    v[TYPE_BIT]          = t;
    v[DEST_MSB:DEST_LSB] = d;
    v[W-1:PAYLOAD_LSB]   = pl;
    return v;
  endfunction

  // Reference model: FIFO contents as a queue of {src, packet}.
  logic [W+1:0] q [$];
  int unsigned  m_rr     = 0;
  bit           m_mis    = 1'b0;
  bit           pend_push = 1'b0;
  bit           pend_pop  = 1'b0;
  logic [W+1:0] pend_entry = '0;
  int unsigned  pend_src  = 0;

  always @(negedge clk) begin : cmp
    int          g;
    int unsigned idx;
    logic [N_IN-1:0] er;
    bit          sp;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk("rst_misroute", 32'(bus.misroute), 0);
      pend_push = 1'b0;
      pend_pop  = 1'b0;
    end else begin
      sp = (q.size() < DEPTH) || (q.size() == DEPTH && bus.out_ready);
      g  = -1;
      for (int unsigned k = 0; k < N_IN; k++) begin
        idx = (m_rr + k) % N_IN;
        if (g < 0 && bus.in_valid[idx]) g = int'(idx);
      end
      er = '0;
      if (sp && g >= 0) er[g] = 1'b1;
      chk("model_in_ready", 32'(bus.in_ready), 32'(er));
      chk("model_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("model_out_data", 32'(bus.out_data), 32'(q[0][W-1:0]));
        chk("model_out_src", 32'(bus.out_src), 32'(q[0][W+1:W]));
      end
      chk("model_misroute", 32'(bus.misroute), 32'(m_mis));
      pend_pop  = (q.size() != 0) && bus.out_ready;
      pend_push = (er != '0);
      if (pend_push) begin
        pend_entry = {2'(g), bus.in_data[g*W +: W]};
        pend_src   = 32'(g);
      end
    end
  end

  always @(posedge clk) begin : upd
    noc_pkt_t p;
    if (rst_n) begin
      if (pend_pop) void'(q.pop_front());
      if (pend_push) begin
        q.push_back(pend_entry);
        m_rr = (pend_src + 1) % N_IN;
        p    = pend_entry[W-1:0];
        if (p.dest != RID) m_mis = 1'b1;
      end
      pend_push = 1'b0;
      pend_pop  = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    m_rr      = 0;
    m_mis     = 1'b0;
    pend_push = 1'b0;
    pend_pop  = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d0, d1, d2, b0, b1;
    d0 = mk(7'h11, 3'd2, 1'b0);
    d1 = mk(7'h22, 3'd2, 1'b1);
    d2 = mk(7'h33, 3'd2, 1'b0);
    b0 = mk(7'h40, 3'd2, 1'b0);
    b1 = mk(7'h51, 3'd2, 1'b1);
    chk("mk_pin", 32'(mk(7'h2A, 3'd2, 1'b1)), 32'h2A5);

    // Reset held with every channel requesting.
    bus.in_data   = {d2, d1, d0};
    bus.in_valid  = 3'b111;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 0);
      chk("reset_out_valid", 32'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round robin: grants 0,1,2,0,1,2 and out_src trails by one cycle.
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.in_ready), 32'(1 << (j % 3)));
      if (j > 0) begin
        chk("rr_out_valid", 32'(bus.out_valid), 1);
        chk("rr_out_src", 32'(bus.out_src), 32'((j - 1) % 3));
      end
    end
    step();
    bus.in_valid = '0;
    repeat (2) step();

    // Single packet latency.
    bus.in_data[W-1:0] = 11'h2A5;
    bus.in_valid       = 3'b001;
    @(negedge clk);
    chk("single_grant", 32'(bus.in_ready), 32'b001);
    step();
    bus.in_valid = '0;
    @(negedge clk);
    chk("single_out_valid", 32'(bus.out_valid), 1);
    chk("single_out_data", 32'(bus.out_data), 32'h2A5);
    chk("single_out_src", 32'(bus.out_src), 0);
    chk("single_misroute", 32'(bus.misroute), 0);
    repeat (2) step();

    // Backpressure: pointer at 1, so channel 1 wins first, then channel 0.
    bus.out_ready         = 1'b0;
    bus.in_data[W-1:0]    = b0;
    bus.in_data[2*W-1:W]  = b1;
    bus.in_valid          = 3'b011;
    @(negedge clk);
    chk("bp_grant0", 32'(bus.in_ready), 32'b010);
    @(negedge clk);
    chk("bp_grant1", 32'(bus.in_ready), 32'b001);
    repeat (3) begin
      @(negedge clk);
      chk("bp_full_ready", 32'(bus.in_ready), 0);
      chk("bp_head_stable", 32'(bus.out_data), 32'(b1));
      chk("bp_head_src", 32'(bus.out_src), 1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_push_grant", 32'(bus.in_ready), 32'b010);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_new_head", 32'(bus.out_data), 32'(b0));
    chk("bp_new_src", 32'(bus.out_src), 0);
    chk("bp_still_full", 32'(bus.in_ready), 0);
    chk("bp_out_valid", 32'(bus.out_valid), 1);
    step();
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    repeat (4) step();

    // Misroute: dest 6 on channel 2, pointer is at 2.
    bus.in_data[3*W-1:2*W] = 11'h00C;
    bus.in_valid           = 3'b100;
    @(negedge clk);
    chk("mis_grant", 32'(bus.in_ready), 32'b100);
    chk("mis_before", 32'(bus.misroute), 0);
    step();
    bus.in_valid = '0;
    @(negedge clk);
    chk("mis_data", 32'(bus.out_data), 32'h00C);
    chk("mis_src", 32'(bus.out_src), 2);
    chk("mis_set", 32'(bus.misroute), 1);
    repeat (3) step();
    @(negedge clk);
    chk("mis_sticky", 32'(bus.misroute), 1);

    // Asynchronous reset pulse while the FIFO holds two packets.
    step();
    bus.out_ready = 1'b0;
    bus.in_data   = {d2, d1, d0};
    bus.in_valid  = 3'b011;
    step();
    step();
    chk("mid_full_valid", 32'(bus.out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_async_valid", 32'(bus.out_valid), 0);
    chk("mid_async_ready", 32'(bus.in_ready), 0);
    chk("mid_async_mis", 32'(bus.misroute), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_no_stale", 32'(bus.out_valid), 0);
    chk("mid_rr_restart", 32'(bus.in_ready), 32'b001);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_first_data", 32'(bus.out_data), 32'(d0));
    chk("mid_first_src", 32'(bus.out_src), 0);
    step();
    bus.in_valid = '0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rl_output_arbiter.md
Name: rl_output_arbiter

Overview:
Clocked merge stage at the receive end of the routing-logic channels.
- Collects 11-bit packets from up to N_IN routing-logic output channels (local, inter-router ±) using valid/ready handshakes.
- Selects one input per cycle with a round-robin arbiter and buffers the winner in a small FIFO.
- Drives a single output link toward the router's output port. This is the consumer/merge counterpart of the per-router packet steering logic.

Parameters:
- WIDTH, 11, packet width: bit0 = type flag, [3:1] = destination router, [10:4] = payload.
- N_IN, 3, number of input channels (2..4 supported).
- DEPTH, 2, FIFO entries (power of two, ≥2).
- ROUTER_ID, 2, 3-bit id of this router; used only for the mis-route flag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N_IN  per-channel packet valid.
- in_ready  out  N_IN  per-channel accept; at most one bit high per cycle.
- in_data  in  N_IN*WIDTH  flattened packets; channel i occupies [i*WIDTH +: WIDTH].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  FIFO head packet.
- out_src  out  2  input index the head packet arrived on.
- misroute  out  1  sticky; set when an accepted packet's [3:1] differs from ROUTER_ID.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied (rd/wr pointers = 0, count = 0); RR pointer = 0.
  - out_valid = 0, out_data = 0, out_src = 0, misroute = 0, in_ready = 0.
  - Takes effect immediately, mid-transfer included: in-flight and buffered packets are discarded, not delivered.
- Push allowed (space) when count < DEPTH, or count == DEPTH and (out_valid && out_ready) in the same cycle.
- Grant is combinational from in_valid, the RR pointer and space:
  - Search starts at the pointer index and proceeds upward modulo N_IN; the first valid channel wins.
  - in_ready[g] = 1 only for the winner g, and only when space is true.
  - in_ready never depends on in_data.
- Transfer on input i occurs when in_valid[i] && in_ready[i] at a rising edge:
  - Packet and src index i are written to the FIFO tail.
  - RR pointer becomes (i+1) mod N_IN.
  - With no transfer, the pointer holds.
- Fairness: with all inputs continuously valid, grants rotate 0,1,2,0,... and no channel waits more than N_IN-1 accepted packets.
- Output:
  - out_valid = (count != 0); out_data and out_src are the registered head entry.
  - Pop when out_valid && out_ready; the head advances at the edge.
  - Head is stable while out_valid && !out_ready.
- Latency: a packet accepted at edge k, into an empty FIFO, is visible on out_valid/out_data after edge k (1 cycle). Back-to-back throughput is 1 packet/cycle when out_ready is held high.
- Simultaneous push and pop:
  - count unchanged.
  - When full, the pop frees the slot written in the same cycle.
  - When count == 1, the new packet becomes head at the next edge with no bubble.
- Pointer arithmetic: wr/rd pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- Protocol assumption on inputs: once in_valid[i] is raised, in_valid and data hold until accepted. The block does not check this.
- misroute: set on any transfer whose dest field != ROUTER_ID. Cleared only by reset. Does not block the packet.
- No combinational path from out_ready to in_ready other than the full-with-pop space term.

Decomposition:
- Shared package noc_pkg holds:
  - WIDTH and field constants TYPE_BIT=0, DEST_LSB=1, DEST_MSB=3, PAYLOAD_LSB=4.
  - typedef noc_pkt_t (packed struct: payload[6:0], dest[2:0], type_flag).
  - typedef router_id_t (3 bits).
- One sub-module, noc_pkt_fifo: parameterised sync FIFO (WIDTH+2 bits wide) with push/pop/full/empty/count and async active-low reset.
- The arbiter and misroute logic stay in the top module.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n low for 3 cycles with all in_valid=1.
  - Required: in_ready=000, out_valid=0, misroute=0 throughout.
  - After release with out_ready=1, the first accept is on channel 0.
- Single packet latency:
  - Stimulus: in_valid=001, in_data[0]=11'h2A5 (dest 2), out_ready=1.
  - Required: accepted at edge k; out_valid=1, out_data=11'h2A5, out_src=0 after edge k; misroute stays 0.
- Round-robin:
  - Stimulus: all three inputs valid continuously with distinct packets, out_ready=1, for 6 cycles.
  - Required: grant order 0,1,2,0,1,2; out_src follows the same order one cycle later.
- Backpressure/full:
  - Stimulus: out_ready=0, inputs 0 and 1 valid.
  - Required: exactly 2 packets accepted, then in_ready=000 while out_data stays stable.
  - Then out_ready=1 for one cycle: one pop, and one new push in the same cycle; count stays 2.
- Misroute:
  - Stimulus: packet 11'h00C (dest 6) on channel 2.
  - Required: delivered unchanged; misroute=1 after the accept edge and sticky until reset.
- Reset mid-operation:
  - Stimulus: FIFO holding 2 packets; pulse rst_n low mid-cycle.
  - Required: out_valid drops immediately without waiting for a clock edge; after release no stale packet appears and the RR pointer restarts at 0.
